rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter that shares one downstream resource, such as a 4-to-2 encoded datapath or a shared bus port, between four clients. It registers a one-hot grant and the matching 2-bit encoded grant index. It enforces a bounded hold time per grant and rotates priority after each grant so that no requester starves. It sits between the requesting clients and the resource's select input: `gnt_id` drives the resource mux select directly.

---
 rtl/rr_arbiter4_if.sv | 24 ++
 rtl/rr_arbiter4.sv | 104 ++++++++++
 tb/tb_rr_arbiter4.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter4_if.sv
// rtl/rr_arbiter4_if.sv - request/grant bundle between four clients and the arbiter
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport master (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-way round-robin arbiter with bounded hold and timeout lockout
module rr_arbiter4 #(
  parameter int HOLD_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter4_if.master bus
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state_q;
  logic [1:0] last_q;
  logic [7:0] hold_cnt_q;
  logic [3:0] blocked_q;
  logic [3:0] blocked_d;
  logic [3:0] gnt_q;
  logic [1:0] gnt_id_q;
  logic       timeout_q;

  logic [3:0] elig;
  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       force_rel;

  assign elig      = bus.req & ~blocked_q;
  assign force_rel = (state_q == GRANT) && bus.req[gnt_id_q] && (hold_cnt_q == HOLD_LAST);

  // Scan from farthest to nearest so the candidate right after last_q wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = last_q;
    cand    = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // A lockout lifts as soon as the client lets go of its request.
  always_comb begin
    blocked_d = blocked_q & bus.req;
    if (force_rel) begin
      blocked_d[gnt_id_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 2'b11;
      hold_cnt_q <= '0;
      blocked_q  <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      blocked_q <= blocked_d;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q    <= GRANT;
            gnt_q      <= 4'b0001 << win_idx;
            gnt_id_q   <= win_idx;
            last_q     <= win_idx;
            hold_cnt_q <= '0;
          end
        end
        GRANT: begin
          if (!bus.req[gnt_id_q]) begin
            state_q <= IDLE;
            gnt_q   <= '0;
          end else if (force_rel) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = |gnt_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - randomized and directed bench for rr_arbiter4 against a behavioural model
module tb_rr_arbiter4;
  localparam int HOLD_MAX = 4;

  logic clk;
  logic rst;
  rr_arbiter4_if bus ();

  rr_arbiter4 #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who owns the resource (-1 = nobody), how many cycles it has had it,
  // the round-robin pointer, and which clients are locked out after a timeout.
  int         m_owner;
  int         m_id;
  int         m_last;
  int         m_held;
  logic [3:0] m_blk;
  logic       m_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic rs);
    int tout;
    tout = -1;
    if (rs) begin
      m_owner = -1;
      m_id    = 0;
      m_last  = 3;
      m_held  = 0;
      m_blk   = '0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_last + k) % 4;
          if (r[c] && !m_blk[c]) begin
            m_owner = c;
            m_id    = c;
            m_last  = c;
            m_held  = 1;
            break;
          end
        end
      end else if (!r[m_owner]) begin
        m_owner = -1;
      end else if (m_held == HOLD_MAX) begin
        tout    = m_owner;
        m_to    = 1'b1;
        m_owner = -1;
      end else begin
        m_held++;
      end
      m_blk = m_blk & r;
      if (tout >= 0) m_blk[tout] = 1'b1;
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic rs);
    logic [3:0] exp_gnt;
    bus.req = r;
    rst     = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
    exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check("gnt",     32'(bus.gnt),     32'(exp_gnt));
    check("gnt_id",  32'(bus.gnt_id),  32'(m_id));
    check("busy",    32'(bus.busy),    32'(m_owner >= 0));
    check("timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  initial begin
    int order [5];
    int k;
    int prev;
    int cnt_g;
    int cnt_t;
    logic seen_to;
    logic done;
    logic [3:0] r;

    order = '{0, 1, 2, 3, 0};
    bus.req = '0;
    rst = 1'b1;

    // Reset, then single request
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    cycle(4'b0001, 1'b0);
    check("single_id", 32'(bus.gnt_id), 32'h0);
    cycle(4'b0001, 1'b0);
    cycle(4'b0001, 1'b0);
    cycle(4'b0000, 1'b0);
    check("single_rel", 32'(bus.gnt), 32'h0);

    // Rotation: every owner lets go after three cycles
    cycle(4'b0000, 1'b1);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      r = 4'hF;
      if (m_owner >= 0 && m_held == 3) r[m_owner] = 1'b0;
      prev = m_owner;
      cycle(r, 1'b0);
      if (prev < 0 && m_owner >= 0 && k < 5) begin
        check("rot_order", 32'(bus.gnt_id), 32'(order[k]));
        k++;
      end
    end
    check("rot_grants", 32'(k), 32'd5);

    // Priority pointer after client 2
    cycle(4'b0000, 1'b1);
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0101, 1'b0);
    check("prio_ptr", 32'(bus.gnt_id), 32'h0);
    cycle(4'b0000, 1'b0);

    // Timeout with a lone requester
    cycle(4'b0000, 1'b1);
    cnt_g = 0;
    cnt_t = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(4'b0010, 1'b0);
      if (bus.gnt == 4'b0010) cnt_g++;
      if (bus.timeout) cnt_t++;
    end
    check("to_hold", 32'(cnt_g), 32'(HOLD_MAX));
    check("to_pulse", 32'(cnt_t), 32'd1);
    cycle(4'b0000, 1'b0);
    cycle(4'b0010, 1'b0);
    check("to_regrant", 32'(bus.gnt), 32'h2);
    cycle(4'b0000, 1'b0);

    // Timeout with a competitor
    cycle(4'b0000, 1'b1);
    seen_to = 1'b0;
    done    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0011, 1'b0);
      if (bus.timeout) seen_to = 1'b1;
      if (seen_to && !done && bus.gnt != 4'b0000) begin
        check("to_comp", 32'(bus.gnt_id), 32'h1);
        done = 1'b1;
      end
    end
    check("to_comp_seen", 32'(done), 32'h1);

    // Reset mid-grant
    cycle(4'b0000, 1'b1);
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b1);
    check("rst_mid_gnt", 32'(bus.gnt), 32'h0);
    check("rst_mid_to", 32'(bus.timeout), 32'h0);
    cycle(4'b0101, 1'b0);
    check("rst_mid_prio", 32'(bus.gnt_id), 32'h0);

    // Random traffic with sticky requests and occasional reset
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 5) == 0) r[j] = ~r[j];
      end
      cycle(r, ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
